// File: rtl/conv3x3_unit.sv
// 3x3 convolution stage: loadable signed kernel, four registered stages
// (multiply, row sums, total, shift+saturate), one pixel per accepted window.
module conv3x3_unit #(
  parameter int unsigned PIXEL_W = 8,
  parameter int unsigned COEF_W  = 8,
  parameter int unsigned TAPS    = 9,
  parameter int unsigned SHIFT   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    window_valid,
  input  logic [TAPS*PIXEL_W-1:0] window_data,
  input  logic                    coef_load,
  input  logic [COEF_W-1:0]       coef_data,
  output logic                    coef_ready,
  output logic [PIXEL_W-1:0]      pixel_out,
  output logic                    pixel_out_valid
);

  localparam int unsigned CNT_W  = $clog2(TAPS);
  localparam int unsigned PROD_W = PIXEL_W + 1 + COEF_W;
  localparam int unsigned ROW_W  = PROD_W + 2;
  localparam int unsigned SUM_W  = ROW_W + 2;
  localparam int unsigned ROWS   = 3;

  logic signed [COEF_W-1:0] coef [TAPS];
  logic [CNT_W-1:0]         coef_count;

  logic                     accept;
  logic                     s1_valid;
  logic                     s2_valid;
  logic                     s3_valid;
  logic signed [PROD_W-1:0] prod [TAPS];
  logic signed [ROW_W-1:0]  row_sum [ROWS];
  logic signed [SUM_W-1:0]  total;
  logic signed [SUM_W-1:0]  shifted;
  logic [PIXEL_W-1:0]       sat_pixel;

  assign accept = window_valid & coef_ready;

  // Coefficient bank; ready only while a complete set sits in the bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) coef[k] <= '0;
      coef_count <= '0;
      coef_ready <= 1'b0;
    end else if (coef_load) begin
      coef[coef_count] <= coef_data;
      if (coef_count == CNT_W'(TAPS - 1)) begin
        coef_count <= '0;
        coef_ready <= 1'b1;
      end else begin
        coef_count <= coef_count + CNT_W'(1);
        coef_ready <= 1'b0;
      end
    end
  end

  // Valid pipeline; reset flushes every window in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else begin
      s1_valid <= accept;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
    end
  end

  // Datapath registers; pixels are zero-extended so they multiply as unsigned.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < TAPS; k++) begin
        prod[k] <= PROD_W'($signed({1'b0, window_data[k*PIXEL_W +: PIXEL_W]}))
                 * PROD_W'(coef[k]);
      end
    end
    if (s1_valid) begin
      for (int r = 0; r < ROWS; r++) begin
        row_sum[r] <= ROW_W'(prod[3*r]) + ROW_W'(prod[3*r+1]) + ROW_W'(prod[3*r+2]);
      end
    end
    if (s2_valid) begin
      total <= SUM_W'(row_sum[0]) + SUM_W'(row_sum[1]) + SUM_W'(row_sum[2]);
    end
  end

  // Floor-divide by 2^SHIFT, then clamp into the pixel range.
  always_comb begin
    shifted   = total >>> SHIFT;
    sat_pixel = shifted[PIXEL_W-1:0];
    if (shifted[SUM_W-1]) begin
      sat_pixel = '0;
    end else if (|shifted[SUM_W-2:PIXEL_W]) begin
      sat_pixel = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_out       <= '0;
      pixel_out_valid <= 1'b0;
    end else begin
      pixel_out_valid <= s3_valid;
      if (s3_valid) pixel_out <= sat_pixel;
    end
  end

endmodule
